keypad_entry: RTL and testbench

Keypad digit-entry receiver for the microwave cook-time path. It consumes the key-code stream produced by the keypad encoder and shifts accepted digits into a three-digit M:SS preset. It filters held keys and contact bounce, and issues a one-cycle load strobe with the preset to the timer when a start is requested. It sits between the keypad encoder and the timer, gated by the control block's magnetron signal.

---
 rtl/keypad_entry_if.sv | 25 ++
 rtl/keypad_entry.sv | 146 ++++++++++++++
 tb/tb_keypad_entry.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// Keypad entry bus: key stream and control from the encoder/control side,
// M:SS preset and load strobe toward the timer.
interface keypad_entry_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       enable;
  logic       clear_entry;
  logic       start_req;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] digit_count;
  logic       entry_full;
  logic       load;

  modport master (
    output key_code, key_valid, enable, clear_entry, start_req,
    input  mins, sec_tens, sec_ones, digit_count, entry_full, load
  );

  modport slave (
    input  key_code, key_valid, enable, clear_entry, start_req,
    output mins, sec_tens, sec_ones, digit_count, entry_full, load
  );
endinterface

// File: rtl/keypad_entry.sv
// Keypad digit-entry receiver: debounced key accept into an M:SS preset, 1-cycle load strobe.
// All outputs registered (1-cycle latency); optional SEC_TENS_CLAMP_EN clamps sec_tens>5 to 5:9 on load.
module keypad_entry #(
  parameter int HOLDOFF = 4
) (
  input  logic           clk,
  input  logic           clr,
  keypad_entry_if.slave  kp
);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    HELD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] low_cnt_q;
  logic [8:0] low_cnt_inc;

  logic [3:0] mins_q, tens_q, ones_q;
  logic [3:0] mins_d, tens_d, ones_d;
  logic [1:0] count_q, count_d;
  logic       full_q, full_d;
  logic       loaded_q, loaded_d;
  logic       load_q, load_d;

  logic       start_go;
  logic       accept;

  assign low_cnt_inc = {1'b0, low_cnt_q} + 9'd1;

  always_comb begin
    start_go = kp.start_req && kp.enable && (count_q != 2'd0);
    accept   = (state_q == ARMED) && kp.key_valid && kp.enable &&
               (kp.key_code <= 4'd9) && (count_q != 2'd3);

    mins_d   = mins_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    load_d   = 1'b0;

    if (kp.clear_entry) begin
      mins_d   = 4'd0;
      tens_d   = 4'd0;
      ones_d   = 4'd0;
      count_d  = 2'd0;
      loaded_d = 1'b0;
    end else if (start_go) begin
      // Digits are kept so the timer sees them alongside the strobe.
      load_d   = 1'b1;
      count_d  = 2'd0;
      loaded_d = 1'b1;
`ifdef SEC_TENS_CLAMP_EN
      if (tens_q > 4'd5) begin
        tens_d = 4'd5;
        ones_d = 4'd9;
      end
`endif
    end else if (accept) begin
      if (loaded_q) begin
        // First key after a load starts a fresh preset.
        mins_d   = 4'd0;
        tens_d   = 4'd0;
        ones_d   = kp.key_code;
        count_d  = 2'd1;
        loaded_d = 1'b0;
      end else begin
        mins_d  = tens_q;
        tens_d  = ones_q;
        ones_d  = kp.key_code;
        count_d = count_q + 2'd1;
      end
    end

    full_d = (count_d == 2'd3);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= ARMED;
      low_cnt_q <= 8'd0;
      mins_q    <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      count_q   <= 2'd0;
      full_q    <= 1'b0;
      loaded_q  <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      mins_q   <= mins_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      count_q  <= count_d;
      full_q   <= full_d;
      loaded_q <= loaded_d;
      load_q   <= load_d;

      // Every press is consumed by the FSM, accepted or not.
      unique case (state_q)
        ARMED: begin
          if (kp.key_valid) begin
            state_q <= HELD;
          end
        end
        HELD: begin
          if (!kp.key_valid) begin
            if (HOLDOFF == 1) begin
              state_q   <= ARMED;
              low_cnt_q <= 8'd0;
            end else begin
              state_q   <= RELEASE;
              low_cnt_q <= 8'd1;
            end
          end
        end
        RELEASE: begin
          if (kp.key_valid) begin
            state_q   <= HELD;
            low_cnt_q <= 8'd0;
          end else if (low_cnt_inc >= 9'(HOLDOFF)) begin
            // Re-arm on the edge that samples the HOLDOFF-th low cycle.
            state_q   <= ARMED;
            low_cnt_q <= 8'd0;
          end else begin
            low_cnt_q <= low_cnt_inc[7:0];
          end
        end
        default: begin
          state_q   <= ARMED;
          low_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  assign kp.mins        = mins_q;
  assign kp.sec_tens    = tens_q;
  assign kp.sec_ones    = ones_q;
  assign kp.digit_count = count_q;
  assign kp.entry_full  = full_q;
  assign kp.load        = load_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry; expected load presets go through a scoreboard queue.
module tb_keypad_entry;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  keypad_entry_if kp();

  keypad_entry #(.HOLDOFF(4)) dut (
    .clk (clk),
    .clr (clr),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  // {mins, sec_tens, sec_ones, digit_count, entry_full}
  function automatic logic [14:0] st();
    return {kp.mins, kp.sec_tens, kp.sec_ones, kp.digit_count, kp.entry_full};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int low);
    kp.key_code  = code;
    kp.key_valid = 1'b1;
    cyc(hold);
    kp.key_valid = 1'b0;
    cyc(low);
  endtask

  // Pulses start_req and watches a bounded window; each load pops the scoreboard.
  task automatic run_start(input string name, input logic exp_load);
    int   seen;
    int   first;
    exp_t e;
    logic [11:0] got;
    seen  = 0;
    first = -1;
    kp.start_req = 1'b1;
    cyc(1);
    kp.start_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (kp.load === 1'b1) begin
        seen++;
        if (first < 0) first = i;
        got = {kp.mins, kp.sec_tens, kp.sec_ones};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected load got %h", name, got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL %s load digits got %h want %h", name, got, e);
          end
        end
      end
      cyc(1);
    end
    checks++;
    if (seen !== (exp_load ? 1 : 0)) begin
      errors++;
      $display("FAIL %s load count got %0d want %0d", name, seen, exp_load ? 1 : 0);
    end
    if (exp_load) begin
      checks++;
      if (first !== 0) begin
        errors++;
        $display("FAIL %s load latency got %0d want 0", name, first);
      end
    end
  endtask

  task automatic test_reset();
    cyc(2);
    checks++;
    if ({st(), kp.load} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", {st(), kp.load});
    end
    clr = 1'b0;
    cyc(1);
  endtask

  task automatic test_entry_load();
    press(4'd1, 3, 4);
    press(4'd3, 3, 4);
    press(4'd0, 3, 4);
    checks++;
    if (st() !== {4'd1, 4'd3, 4'd0, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL entry_130 got %h want %h", st(), {4'd1, 4'd3, 4'd0, 2'd3, 1'b1});
    end
    sb.push_back('{m: 4'd1, t: 4'd3, o: 4'd0});
    run_start("load_130", 1'b1);
    checks++;
    if (st() !== {4'd1, 4'd3, 4'd0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL after_load got %h want %h", st(), {4'd1, 4'd3, 4'd0, 2'd0, 1'b0});
    end
  endtask

  task automatic test_reentry();
    press(4'd4, 3, 4);
    checks++;
    if (st() !== {4'd0, 4'd0, 4'd4, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL reentry got %h want %h", st(), {4'd0, 4'd0, 4'd4, 2'd1, 1'b0});
    end
  endtask

  task automatic test_bounce();
    kp.clear_entry = 1'b1;
    cyc(1);
    kp.clear_entry = 1'b0;
    checks++;
    if (st() !== 15'h0) begin
      errors++;
      $display("FAIL clear_entry got %h want 0", st());
    end
    kp.key_code  = 4'd5;
    kp.key_valid = 1'b1;
    cyc(2);
    kp.key_valid = 1'b0;
    cyc(2);
    kp.key_valid = 1'b1;
    cyc(1);
    kp.key_valid = 1'b0;
    cyc(4);
    checks++;
    if (st() !== {4'd0, 4'd0, 4'd5, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL bounce got %h want %h", st(), {4'd0, 4'd0, 4'd5, 2'd1, 1'b0});
    end
  endtask

  task automatic test_full_invalid();
    press(4'd12, 3, 4);
    checks++;
    if (st() !== {4'd0, 4'd0, 4'd5, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL invalid_code got %h want %h", st(), {4'd0, 4'd0, 4'd5, 2'd1, 1'b0});
    end
    press(4'd2, 3, 4);
    press(4'd3, 3, 4);
    press(4'd7, 3, 4);
    checks++;
    if (st() !== {4'd5, 4'd2, 4'd3, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL full_entry got %h want %h", st(), {4'd5, 4'd2, 4'd3, 2'd3, 1'b1});
    end
  endtask

  task automatic test_holdoff();
    kp.clear_entry = 1'b1;
    cyc(1);
    kp.clear_entry = 1'b0;
    press(4'd1, 3, 3);
    press(4'd2, 3, 4);
    checks++;
    if (st() !== {4'd0, 4'd0, 4'd1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL holdoff_short got %h want %h", st(), {4'd0, 4'd0, 4'd1, 2'd1, 1'b0});
    end
  endtask

  task automatic test_simultaneous();
    kp.clear_entry = 1'b1;
    run_start("clear_with_start", 1'b0);
    kp.clear_entry = 1'b0;
    checks++;
    if (st() !== 15'h0) begin
      errors++;
      $display("FAIL clear_start_state got %h want 0", st());
    end
    run_start("start_empty", 1'b0);
    kp.enable = 1'b0;
    press(4'd6, 3, 4);
    kp.enable = 1'b1;
    checks++;
    if (st() !== 15'h0) begin
      errors++;
      $display("FAIL disabled_key got %h want 0", st());
    end
  endtask

  task automatic test_async_clear();
    press(4'd9, 3, 4);
    kp.start_req = 1'b1;
    cyc(1);
    kp.start_req = 1'b0;
    checks++;
    if (kp.load !== 1'b1) begin
      errors++;
      $display("FAIL pending_load got %b want 1", kp.load);
    end
    clr = 1'b1;
    #1;
    checks++;
    if ({st(), kp.load} !== 16'h0) begin
      errors++;
      $display("FAIL async_clr got %h want 0", {st(), kp.load});
    end
    #2;
    clr = 1'b0;
    cyc(1);
  endtask

  task automatic test_clamp();
    press(4'd1, 3, 4);
    press(4'd8, 3, 4);
    press(4'd2, 3, 4);
`ifdef SEC_TENS_CLAMP_EN
    sb.push_back('{m: 4'd1, t: 4'd5, o: 4'd9});
`else
    sb.push_back('{m: 4'd1, t: 4'd8, o: 4'd2});
`endif
    run_start("clamp_load", 1'b1);
  endtask

  initial begin
    kp.key_code    = 4'd0;
    kp.key_valid   = 1'b0;
    kp.enable      = 1'b1;
    kp.clear_entry = 1'b0;
    kp.start_req   = 1'b0;
    #1;
    test_reset();
    test_entry_load();
    test_reentry();
    test_bounce();
    test_full_invalid();
    test_holdoff();
    test_simultaneous();
    test_async_clear();
    test_clamp();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
